shared_mem_arbiter: RTL
=======================

SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 14: RAM word-address width.
REQ-002 msoc_clk  in  1  sole clock; all state on rising edge.
REQ-003 rstn  in  1  reset, asynchronous, active-low.
REQ-004 mN_req  in  1  requester N (N=0 minion LSU, N=1 host) access request.
REQ-005 mN_we  in  1  write when 1, read when 0.
REQ-006 mN_addr  in  ADDR_W  word address.
REQ-007 mN_be  in  4  byte enables, bit i selects wdata[8i+7:8i].
REQ-008 mN_wdata  in  32  write data.
REQ-009 mN_lock  in  1  holds grant across consecutive accesses while asserted.
REQ-010 mN_gnt  out  1  access accepted this cycle.
REQ-011 mN_rvalid  out  1  response for access granted previous cycle.
REQ-012 mN_rdata  out  32  read data, meaningful only with mN_rvalid.
REQ-013 ram_ce, ram_we  out  1 each  RAM enable / write enable.
REQ-014 ram_addr  out  ADDR_W; ram_be  out  4; ram_wdata  out  32: RAM command.
REQ-015 ram_rdata  in  32  RAM read data, valid one cycle after ram_ce.

Function
REQ-016 Grant combinational: at most one mN_gnt per cycle; mN_gnt only when mN_req=1.
REQ-017 Granted requester's we/addr/be/wdata drive RAM same cycle; ram_ce = m0_gnt | m1_gnt; ram_we = ram_ce & granted we.
REQ-018 No grant: ram_ce=0, ram_we=0, ram_addr/ram_be/ram_wdata=0.
REQ-019 Response latency exactly 1 cycle: grant in cycle T gives mN_rvalid=1 in T+1 for reads and writes, to that requester only.
REQ-020 mN_rdata = ram_rdata when mN_rvalid=1, else 0.
REQ-021 Back-to-back grants allowed every cycle; response register (resp_valid, resp_id) updated each cycle.
REQ-022 Single request: granted immediately, regardless of priority state.
REQ-023 Both requesting, no lock: winner per Configuration (REQ-030/031).
REQ-024 Lock FSM states UNLOCKED, LOCK0, LOCK1; reset to UNLOCKED.
REQ-025 UNLOCKED -> LOCKn when mN_gnt=1 and mN_lock=1 in the same cycle.
REQ-026 LOCKn: only requester n may be granted; other requester stalls with gnt=0 even if n idle.
REQ-027 LOCKn -> UNLOCKED on first cycle mn_lock=0 (arbitration resumes that cycle).
REQ-028 last_gnt register records last granted requester; unchanged in cycles without grant.
REQ-029 Request with req deasserted before grant is dropped; no response issued.

Configuration
REQ-030 With ARB_ROUND_ROBIN_EN defined: on contention grant the requester not equal to last_gnt.
REQ-031 Without ARB_ROUND_ROBIN_EN: fixed priority, m0 always wins contention; last_gnt still maintained.

Reset
REQ-032 rstn=0 forces immediately: lock FSM UNLOCKED, last_gnt=1 (m0 wins first contention), resp_valid=0, all mN_rvalid=0, mN_rdata=0.
REQ-033 During reset mN_gnt=0 and ram_ce=0 regardless of requests.
REQ-034 Reset mid-access: pending response discarded; no rvalid after reset release.

Verification
REQ-035 m0 read addr 0x010, RAM word 0xDEADBEEF -> m0_gnt same cycle, m0_rvalid next cycle, m0_rdata=0xDEADBEEF, m1_rvalid=0.
REQ-036 Both req continuously 4 cycles, ARB_ROUND_ROBIN_EN defined -> grants m0,m1,m0,m1; undefined -> m0 x4, m1_gnt=0.
REQ-037 m1 write addr 0x020 be=4'b0011 wdata 0x12345678, then m0 read 0x020 (prior 0xAAAAAAAA) -> m0_rdata=0xAAAA5678.
REQ-038 m1_lock=1 for 3 grants with m0_req=1 throughout -> m1 gnt 3 cycles, m0_gnt=0; m0 granted first cycle m1_lock=0.
REQ-039 rstn pulsed low cycle after m0 read grant -> m0_rvalid=0 immediately and after release; FSM UNLOCKED.
REQ-040 Alternating single requests m0,m1,m0 on consecutive cycles -> each granted without stall, rvalid routed to correct requester each following cycle.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: two-requester arbiter in front of a single-port RAM.
// Requester 0 is the minion LSU, requester 1 is the host. Grants are
// combinational, responses come back exactly one cycle after the grant.
// A requester may hold the RAM across several accesses with its lock input.
// Optional feature: define ARB_ROUND_ROBIN_EN for alternating priority on
// contention; otherwise requester 0 always wins contention.
module shared_mem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              msoc_clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [3:0]        m0_be,
  input  logic [31:0]       m0_wdata,
  input  logic              m0_lock,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [3:0]        m1_be,
  input  logic [31:0]       m1_wdata,
  input  logic              m1_lock,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              ram_ce,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [3:0]        ram_be,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata
);

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    LOCK0    = 2'd1,
    LOCK1    = 2'd2
  } lock_state_e;

  lock_state_e state_q, state_d;
  logic        last_gnt_q, last_gnt_d;   // 0: m0 granted last, 1: m1
  logic        resp_valid_q, resp_valid_d;
  logic        resp_id_q, resp_id_d;
  logic        arb_free_s;               // normal arbitration this cycle

  // Lock handling, grant selection and next-state for lock FSM / last_gnt.
  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    // A lock owner that drops its lock releases the RAM in that same cycle.
    case (state_q)
      LOCK0:   arb_free_s = ~m0_lock;
      LOCK1:   arb_free_s = ~m1_lock;
      default: arb_free_s = 1'b1;
    endcase
    if (!rstn) begin
      m0_gnt = 1'b0;
      m1_gnt = 1'b0;
    end else if (!arb_free_s) begin
      // Locked: only the owner may be granted, the other one stalls.
      if (state_q == LOCK0) begin
        m0_gnt = m0_req;
      end else begin
        m1_gnt = m1_req;
      end
    end else if (m0_req && m1_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      m0_gnt = last_gnt_q;
      m1_gnt = ~last_gnt_q;
`else
      m0_gnt = 1'b1;
      m1_gnt = 1'b0;
`endif
    end else begin
      m0_gnt = m0_req;
      m1_gnt = m1_req;
    end

    if (!arb_free_s) begin
      state_d = state_q;
    end else if (m0_gnt && m0_lock) begin
      state_d = LOCK0;
    end else if (m1_gnt && m1_lock) begin
      state_d = LOCK1;
    end else begin
      state_d = UNLOCKED;
    end

    if (m0_gnt) begin
      last_gnt_d = 1'b0;
    end else if (m1_gnt) begin
      last_gnt_d = 1'b1;
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // RAM command mux: granted requester drives the RAM, zeros when idle.
  always_comb begin
    ram_ce    = m0_gnt | m1_gnt;
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_be    = 4'd0;
    ram_wdata = 32'd0;
    if (m0_gnt) begin
      ram_we    = m0_we;
      ram_addr  = m0_addr;
      ram_be    = m0_be;
      ram_wdata = m0_wdata;
    end else if (m1_gnt) begin
      ram_we    = m1_we;
      ram_addr  = m1_addr;
      ram_be    = m1_be;
      ram_wdata = m1_wdata;
    end else begin
      ram_we    = 1'b0;
    end
  end

  // Response tracking: every grant yields one response the next cycle.
  always_comb begin
    resp_valid_d = m0_gnt | m1_gnt;
    resp_id_d    = m1_gnt;
  end

  // Response routing: read data only reaches the requester being answered.
  always_comb begin
    m0_rvalid = resp_valid_q & ~resp_id_q;
    m1_rvalid = resp_valid_q & resp_id_q;
    m0_rdata  = m0_rvalid ? ram_rdata : 32'd0;
    m1_rdata  = m1_rvalid ? ram_rdata : 32'd0;
  end

  // State registers; last_gnt resets to 1 so m0 wins the first contention.
  always_ff @(posedge msoc_clk or negedge rstn) begin
    if (!rstn) begin
      state_q      <= UNLOCKED;
      last_gnt_q   <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_gnt_q   <= last_gnt_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
    end
  end

endmodule
